// File: rtl/pipe_skid_reg.sv
// pipe_skid_reg: 2-entry skid-buffered pipeline register with stall/flush; optional instruction field decode under PIPE_SKID_REG_DECODE_EN.
module pipe_skid_reg #(
    parameter int DATA_W = 32
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              stall,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
`ifdef PIPE_SKID_REG_DECODE_EN
    ,
    output logic [5:0]        opcode,
    output logic [4:0]        rs,
    output logic [4:0]        rt,
    output logic [4:0]        rd,
    output logic [5:0]        func,
    output logic [15:0]       imm16
`endif
);
    typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;
    state_t state, state_n;
    logic [DATA_W-1:0] main_q, main_n, skid_q, skid_n;
    logic in_fire, out_fire;
    assign in_ready  = (state != FULL) & ~stall & ~flush;
    assign out_valid = (state != EMPTY) & ~stall & ~flush;
    assign out_data  = main_q;
    assign occupancy = state;
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;
    // Stall needs no explicit hold: it already gates both fires to 0.
    always_comb begin
        state_n = state;
        main_n  = main_q;
        skid_n  = skid_q;
        if (flush) begin
            state_n = EMPTY;
            main_n  = '0;
            skid_n  = '0;
        end else begin
            case (state)
                EMPTY: if (in_fire) begin
                    state_n = ONE;
                    main_n  = in_data;
                end
                ONE: if (in_fire & out_fire) begin
                    main_n = in_data;
                end else if (in_fire) begin
                    state_n = FULL;
                    skid_n  = in_data;
                end else if (out_fire) begin
                    state_n = EMPTY;
                    main_n  = '0;
                end
                FULL: if (out_fire) begin
                    state_n = ONE;
                    main_n  = skid_q;
                    skid_n  = '0;
                end
                default: begin
                    state_n = EMPTY;
                    main_n  = '0;
                    skid_n  = '0;
                end
            endcase
        end
    end
    always_ff @(posedge CLK) begin
        if (RST) begin
            state  <= EMPTY;
            main_q <= '0;
            skid_q <= '0;
        end else begin
            state  <= state_n;
            main_q <= main_n;
            skid_q <= skid_n;
        end
    end
`ifdef PIPE_SKID_REG_DECODE_EN
    if (DATA_W < 32) begin : g_bad_width
        $error("pipe_skid_reg: decode requires DATA_W >= 32");
    end
    assign opcode = out_data[31:26];
    assign rs     = out_data[25:21];
    assign rt     = out_data[20:16];
    assign rd     = out_data[15:11];
    assign func   = out_data[5:0];
    assign imm16  = out_data[15:0];
`endif
endmodule

// File: tb/tb_pipe_skid_reg.sv
// tb_pipe_skid_reg: directed plus random checks of pipe_skid_reg against a queue-based model.
module tb_pipe_skid_reg;
    logic        clk = 0;
    logic        rst, in_valid, stall, flush, out_ready;
    logic [31:0] in_data;
    logic        in_ready, out_valid;
    logic [31:0] out_data;
    logic [1:0]  occupancy;
`ifdef PIPE_SKID_REG_DECODE_EN
    logic [5:0]  opcode, func;
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm16;
`endif
    int n_cmp = 0, n_bad = 0;
    logic [31:0] mq[$];
    bit m_ok = 0;

    pipe_skid_reg #(.DATA_W(32)) dut (
        .CLK(clk), .RST(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .stall(stall), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .occupancy(occupancy)
`ifdef PIPE_SKID_REG_DECODE_EN
        , .opcode(opcode), .rs(rs), .rt(rt), .rd(rd), .func(func), .imm16(imm16)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: a FIFO of held payloads, at most two deep.
    always @(posedge clk) begin
        if (rst) begin
            mq.delete();
            m_ok = 1;
        end else if (m_ok && flush) begin
            mq.delete();
        end else if (m_ok && !stall) begin
            bit take, give;
            take = in_valid && mq.size() < 2;
            give = out_ready && mq.size() > 0;
            if (give) void'(mq.pop_front());
            if (take) mq.push_back(in_data);
        end
    end

    always @(negedge clk) begin
        if (m_ok) begin
            int n;
            n = mq.size();
            chk("m_in_ready", {31'd0, in_ready}, {31'd0, n < 2 && !stall && !flush});
            chk("m_out_valid", {31'd0, out_valid}, {31'd0, n > 0 && !stall && !flush});
            chk("m_out_data", out_data, n > 0 ? mq[0] : 32'd0);
            chk("m_occupancy", {30'd0, occupancy}, n);
        end
    end

    task automatic drive(input logic iv, input logic [31:0] d, input logic ordy,
                         input logic st = 0, input logic fl = 0, input logic r = 0);
        @(posedge clk);
        #1;
        in_valid = iv; in_data = d; out_ready = ordy; stall = st; flush = fl; rst = r;
    endtask

    task automatic neg();
        @(negedge clk);
    endtask

    initial begin
        rst = 1; in_valid = 0; in_data = 0; stall = 0; flush = 0; out_ready = 0;
        drive(0, 0, 0, 0, 0, 1);
        drive(0, 0, 0);
        neg();
        chk("rst_out_valid", {31'd0, out_valid}, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_occ", {30'd0, occupancy}, 0);
        chk("rst_in_ready", {31'd0, in_ready}, 1);
        // streaming 1..4
        drive(1, 1, 1);
        for (int i = 2; i <= 5; i++) begin
            drive(i <= 4, i <= 4 ? i : 0, 1);
            neg();
            chk("stream_data", out_data, i - 1);
            chk("stream_occ", {30'd0, occupancy}, 1);
        end
        drive(0, 0, 1);
        neg();
        chk("stream_drain_occ", {30'd0, occupancy}, 0);
        // backpressure
        drive(1, 'hA, 0);
        drive(1, 'hB, 0);
        neg();
        chk("bp_occ1", {30'd0, occupancy}, 1);
        drive(1, 'hC, 0);
        neg();
        chk("bp_occ2", {30'd0, occupancy}, 2);
        chk("bp_in_ready", {31'd0, in_ready}, 0);
        drive(1, 'hC, 1);
        neg();
        chk("bp_out_a", out_data, 'hA);
        drive(1, 'hC, 1);
        neg();
        chk("bp_out_b", out_data, 'hB);
        drive(0, 0, 1);
        neg();
        chk("bp_out_c", out_data, 'hC);
        drive(0, 0, 0);
        neg();
        chk("bp_empty", {30'd0, occupancy}, 0);
        // stall
        drive(1, 5, 0);
        drive(1, 6, 0);
        for (int i = 0; i < 3; i++) begin
            drive(1, 7, 1, 1);
            neg();
            chk("st_in_ready", {31'd0, in_ready}, 0);
            chk("st_out_valid", {31'd0, out_valid}, 0);
            chk("st_occ", {30'd0, occupancy}, 2);
        end
        drive(0, 0, 1);
        neg();
        chk("st_out5", out_data, 5);
        drive(0, 0, 1);
        neg();
        chk("st_out6", out_data, 6);
        // flush
        drive(1, 'h11, 0);
        drive(1, 'h12, 0);
        drive(1, 9, 1, 0, 1);
        drive(0, 0, 1);
        neg();
        chk("fl_occ", {30'd0, occupancy}, 0);
        chk("fl_data", out_data, 0);
        chk("fl_valid", {31'd0, out_valid}, 0);
        // reset mid-operation
        drive(1, 'h21, 0);
        drive(1, 'h22, 0);
        drive(1, 'h23, 1, 0, 0, 1);
        drive(0, 0, 1);
        neg();
        chk("mr_occ", {30'd0, occupancy}, 0);
        chk("mr_valid", {31'd0, out_valid}, 0);
        chk("mr_in_ready", {31'd0, in_ready}, 1);
`ifdef PIPE_SKID_REG_DECODE_EN
        drive(1, 32'h012A4020, 0);
        drive(0, 0, 0);
        neg();
        chk("dec_opcode", {26'd0, opcode}, 0);
        chk("dec_rs", {27'd0, rs}, 9);
        chk("dec_rt", {27'd0, rt}, 10);
        chk("dec_rd", {27'd0, rd}, 8);
        chk("dec_func", {26'd0, func}, 'h20);
        chk("dec_imm16", {16'd0, imm16}, 'h4020);
`endif
        // random traffic; the model checks every cycle
        for (int i = 0; i < 3000; i++)
            drive($urandom_range(9, 0) < 7, $urandom, $urandom_range(9, 0) < 6,
                  $urandom_range(9, 0) == 0, $urandom_range(99, 0) < 3,
                  $urandom_range(99, 0) == 0);
        drive(0, 0, 1);
        neg();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
